// File: rtl/relu_pack_ctrl_pkg.sv
// Shared types and sizes for the accumulator-to-feature-map output sequencer.
// Imported by the controller and its ReLU/clamp stage.
package relu_pack_ctrl_pkg;

    localparam int ACC_W   = 32;
    localparam int SHIFT_W = 5;
    localparam int LANES   = 4;
    localparam int LANE_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/relu_pack_ctrl_relu8b.sv
// Combinational shift, ReLU and 8-bit saturation of one accumulator.
// Negative inputs map to zero before any shifting is considered.
module relu_pack_ctrl_relu8b
    import relu_pack_ctrl_pkg::*;
(
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [7:0]         o_y
);

    logic [ACC_W-1:0] w_shifted;

    assign w_shifted = i_acc >> i_shift;

    always_comb begin
        if (i_acc[ACC_W-1]) begin
            o_y = 8'h00;
        end else if (|w_shifted[ACC_W-1:8]) begin
            o_y = 8'hFF;
        end else begin
            o_y = w_shifted[7:0];
        end
    end

endmodule

// File: rtl/relu_pack_ctrl.sv
// Output-stage sequencer: pulls accumulators, applies ReLU/clamp,
// packs four bytes per word and streams the words out.
module relu_pack_ctrl
    import relu_pack_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               busy,
    output logic               done,
    input  logic               acc_valid,
    input  logic [ACC_W-1:0]   acc_data,
    output logic               acc_ready,
    output logic               out_valid,
    output logic [ACC_W-1:0]   out_data,
    output logic [LANES-1:0]   out_be,
    output logic               out_last,
    input  logic               out_ready
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [SHIFT_W-1:0] r_shift;
    logic [LEN_W-1:0]   r_remaining;
    logic [LANE_W-1:0]  r_lane;
    logic [ACC_W-1:0]   r_pack;
    logic [LANES-1:0]   r_be;
    logic [ACC_W-1:0]   r_out_data;
    logic [LANES-1:0]   r_out_be;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_done;

    logic [7:0]         w_byte;
    logic               w_start_ok;
    logic               w_xfer;
    logic               w_final;
    logic               w_word;
    logic               w_out_hs;
    logic               w_done_set;
    logic [ACC_W-1:0]   w_pack_nx;
    logic [LANES-1:0]   w_be_nx;

    relu_pack_ctrl_relu8b u_relu8b (
        .i_acc   (acc_data),
        .i_shift (r_shift),
        .o_y     (w_byte)
    );

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign acc_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_xfer     = acc_valid && acc_ready;
    assign w_final    = (r_remaining == LEN_W'(1));
    assign w_word     = w_xfer && ((r_lane == LANE_W'(LANES - 1)) || w_final);
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_pack_nx  = r_pack | (ACC_W'(w_byte) << {r_lane, 3'b000});
    assign w_be_nx    = r_be | (LANES'(1) << r_lane);

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_be    = r_out_be;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_done_set = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_xfer && w_final) begin
                    w_state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hs && r_out_last) begin
                    w_done_set = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_be        <= '0;
            r_out_data  <= '0;
            r_out_be    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_start_ok) begin
                r_shift     <= cfg_shift;
                r_remaining <= cfg_len;
                r_lane      <= '0;
                r_pack      <= '0;
                r_be        <= '0;
            end else if (w_xfer) begin
                r_remaining <= r_remaining - LEN_W'(1);
                if (w_word) begin
                    r_lane <= '0;
                    r_pack <= '0;
                    r_be   <= '0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_pack <= w_pack_nx;
                    r_be   <= w_be_nx;
                end
            end
            // a load may coincide with the handshake of the previous word
            if (w_word) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pack_nx;
                r_out_be    <= w_be_nx;
                r_out_last  <= w_final;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/relu_pack_ctrl.md
# relu_pack_ctrl

Output-stage sequencer for the accumulator-to-feature-map path. On `start` it latches a shift amount and an element count, then pulls 32-bit signed accumulators over a valid/ready stream and passes each one through a `relu8b` instance (right shift, ReLU, clamp to 8 bits). It packs four results per 32-bit word and pushes the words to the output buffer over a second valid/ready stream, then pulses `done`.

## Interface
- `LEN_W`, 16: width of the element-count field.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: job start pulse; sampled only in IDLE.
- `cfg_shift` in 5: accumulator right-shift amount; latched on accepted `start`.
- `cfg_len` in LEN_W: number of accumulators in the job; latched on accepted `start`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at job end.
- `acc_valid` in 1: accumulator available.
- `acc_data` in 32: accumulator, two's complement.
- `acc_ready` out 1: controller accepts `acc_data` this cycle.
- `out_valid` out 1: packed word available.
- `out_data` out 32: packed bytes; element 0 of the word is in [7:0].
- `out_be` out 4: byte enables for `out_data`.
- `out_last` out 1: marks the final word of the job.
- `out_ready` in 1: sink accepts the word this cycle.

## Operation
- FSM states and transitions:
  - IDLE: `start` with `cfg_len` != 0 goes to RUN. `start` with `cfg_len` == 0 pulses `done` next cycle and stays in IDLE.
  - RUN: a transfer occurs when `acc_valid` && `acc_ready`. `acc_ready` = RUN && (!`out_valid` || `out_ready`).
  - Each transfer writes `relu8b(acc_data, shift_q)` into byte lane `lane`, sets that `be` bit, increments `lane` (2-bit, wraps), and decrements `remaining`.
  - Word registration: when `lane` == 3 or `remaining` == 1, the packed word, its `be`, and `out_last` (= `remaining` == 1) load into the output register. The pack register and `be` then clear and `lane` resets to 0.
  - After the final transfer, go to DRAIN.
  - DRAIN: on the `out_valid` && `out_ready` handshake of the `out_last` word, pulse `done` and go to IDLE.
- Clamp rules:
  - Negative accumulator (bit 31 set) gives 0x00, regardless of shift.
  - Shifted value > 255 gives 0xFF.
  - Otherwise the result is the shifted value [7:0].
- Partial final word: unused upper bytes are 0x00 and their `out_be` bits are 0.
- Once loaded, `out_data`, `out_be` and `out_last` hold stable until handshake.
- `start` is ignored while `busy`.
- Mid-job changes to `cfg_*` have no effect.
- A simultaneous output handshake and new-word load in the same cycle is legal and loses no data.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `acc_ready`, `out_valid`, `out_last` = 0.
  - `out_data` = 0, `out_be` = 0.
  - `lane` and `remaining` = 0.
- Reset mid-job aborts immediately. No `done` is produced and partial words are discarded.
- `busy` rises the cycle after an accepted `start`. `acc_ready` can first be high that same cycle.
- Latency: `out_valid` asserts the cycle after the transfer that completes a word.
- Throughput: 1 accumulator per cycle with `out_ready` held high, i.e. one word per 4 cycles and no bubbles.
- `done` rises the cycle after the final output handshake.
- Next `start` is accepted from the cycle `done` is high.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, RUN, DRAIN).
  - Accumulator width (32), shift width (5), byte-lane count (4).
- One sub-module: the existing combinational `relu8b`, instantiated once on `acc_data` / `shift_q`.
- Everything else stays in this module: FSM, `lane` and `remaining` counters, pack register, output register.

## Test plan
- Clamp, shift 0, len 4: inputs 5, 300, 0xFFFFFFFF, 0x80 -> `out_data` 0x80_00_FF_05, `out_be` 0xF, `out_last` 1, then `done`.
- Shift 4, len 4: inputs 0x7F0, 0xFF0, 0x1000, 0x80000010 -> 0x00_FF_FF_7F.
- Partial word, len 6, values 1..6, shift 0:
  - Word 1 is 0x04030201, `be` 0xF, `last` 0.
  - Word 2 is 0x00000605, `be` 0x3, `last` 1.
- Backpressure: hold `out_ready` low 10 cycles mid-job.
  - `acc_ready` drops after the next word completes.
  - `out_data` stays stable.
  - No loss or duplication over len 16 with random `acc_valid` / `out_ready`.
- Control edges:
  - `cfg_len` 0 -> `done` the next cycle with no output.
  - `start` during RUN is ignored.
  - Assert `rst` after 3 transfers -> all outputs at reset values. A fresh len-4 job then completes correctly.
